// File: rtl/glb_dma_ld_nd.sv
// rtl/glb_dma_ld_nd.sv - header-queued nested-loop GLB read address generator (optional GLB_DMA_LD_REPEAT_EN)
module glb_dma_ld_nd #(
    parameter int QUEUE_DEPTH    = 4,
    parameter int LOOP_LEVEL     = 3,
    parameter int GLB_ADDR_WIDTH = 22,
    parameter int CNT_WIDTH      = 21
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 hdr_wr_en,
    input  logic [GLB_ADDR_WIDTH-1:0]            hdr_start_addr,
    input  logic [LOOP_LEVEL*CNT_WIDTH-1:0]      hdr_extent,
    input  logic [LOOP_LEVEL*GLB_ADDR_WIDTH-1:0] hdr_stride,
    input  logic                                 hdr_repeat_on,
    output logic                                 hdr_full,
    output logic                                 hdr_overflow,
    output logic [$clog2(QUEUE_DEPTH):0]         queue_count,
    input  logic                                 start_pulse,
    input  logic                                 abort,
    output logic                                 rd_en,
    output logic [GLB_ADDR_WIDTH-1:0]            rd_addr,
    input  logic                                 rd_ready,
    output logic                                 busy,
    output logic                                 done_pulse
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int AW = GLB_ADDR_WIDTH;
    localparam int EW = LOOP_LEVEL*CNT_WIDTH;
    localparam int SW = LOOP_LEVEL*GLB_ADDR_WIDTH;

    typedef enum logic {S_IDLE, S_RUN} state_t;
    state_t r_state, w_state_nxt;

    logic [AW-1:0]        r_q_addr [QUEUE_DEPTH];
    logic [EW-1:0]        r_q_ext  [QUEUE_DEPTH];
    logic [SW-1:0]        r_q_str  [QUEUE_DEPTH];
    logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
    logic [PW:0]          r_count;

    logic [CNT_WIDTH-1:0] r_idx  [LOOP_LEVEL];
    logic [AW-1:0]        r_base [LOOP_LEVEL];
    logic [EW-1:0]        r_ext;
    logic [SW-1:0]        r_str;
    logic                 r_done, r_ovf;

    logic [CNT_WIDTH-1:0] w_nidx  [LOOP_LEVEL];
    logic [AW-1:0]        w_nbase [LOOP_LEVEL];
    logic [LOOP_LEVEL-1:0] w_wrap, w_inc;
    logic [CNT_WIDTH-1:0] w_ext_i;
    logic [AW-1:0]        w_sval;
    logic                 w_carry, w_found, w_zero, w_last;
    logic                 w_full, w_empty, w_acc, w_fin, w_start, w_pop, w_push, w_rep;
    logic [PW-1:0]        w_push_ptr;

`ifdef GLB_DMA_LD_REPEAT_EN
    logic                 r_q_rep [QUEUE_DEPTH];
    assign w_rep = w_pop && r_q_rep[r_rd_ptr];
`else
    logic                 w_unused_rep;
    assign w_unused_rep = hdr_repeat_on;
    assign w_rep        = 1'b0;
`endif

    assign w_full     = (r_count == (PW+1)'(QUEUE_DEPTH));
    assign w_empty    = (r_count == '0);
    assign rd_en      = (r_state == S_RUN) && !w_zero;
    assign w_acc      = rd_en && rd_ready;
    assign w_fin      = (r_state == S_RUN) && (w_zero || (w_acc && w_last));
    assign w_start    = (r_state == S_IDLE) && start_pulse && !w_empty;
    assign w_pop      = !abort && !w_empty && (w_start || w_fin);
    // a recirculated header takes the tail slot ahead of any external push
    assign w_push     = hdr_wr_en && !w_full && !abort;
    assign w_push_ptr = r_wr_ptr + PW'(w_rep);

    assign hdr_full     = w_full;
    assign hdr_overflow = r_ovf;
    assign queue_count  = r_count;
    assign rd_addr      = r_base[0];
    assign busy         = (r_state == S_RUN);
    assign done_pulse   = r_done;

    // loop-nest carry chain: next indices and next base addresses on acceptance
    always_comb begin
        w_zero  = 1'b0;
        w_carry = 1'b1;
        w_found = 1'b0;
        w_sval  = '0;
        w_ext_i = '0;
        w_wrap  = '0;
        w_inc   = '0;
        for (int i = 0; i < LOOP_LEVEL; i++) begin
            w_ext_i   = r_ext[i*CNT_WIDTH +: CNT_WIDTH];
            if (w_ext_i == '0) w_zero = 1'b1;
            w_wrap[i] = (r_idx[i] == (w_ext_i - CNT_WIDTH'(1)));
            w_inc[i]  = w_carry;
            w_nidx[i] = w_carry ? (w_wrap[i] ? '0 : r_idx[i] + CNT_WIDTH'(1)) : r_idx[i];
            w_carry   = w_carry && w_wrap[i];
        end
        w_last = w_carry;
        for (int i = LOOP_LEVEL-1; i >= 0; i--) begin
            if (!w_found && w_inc[i] && !w_wrap[i]) begin
                w_found = 1'b1;
                w_sval  = r_base[i] + r_str[i*AW +: AW];
            end
            w_nbase[i] = w_found ? w_sval : r_base[i];
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // next state: abort always wins and returns to idle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_fin && w_empty) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (abort) w_state_nxt = S_IDLE;
    end

    // header storage writes: recirculated head first, then external push
    always_ff @(posedge clk) begin
`ifdef GLB_DMA_LD_REPEAT_EN
        if (w_rep) begin
            r_q_addr[r_wr_ptr] <= r_q_addr[r_rd_ptr];
            r_q_ext[r_wr_ptr]  <= r_q_ext[r_rd_ptr];
            r_q_str[r_wr_ptr]  <= r_q_str[r_rd_ptr];
            r_q_rep[r_wr_ptr]  <= 1'b1;
        end
        if (w_push) r_q_rep[w_push_ptr] <= hdr_repeat_on;
`endif
        if (w_push) begin
            r_q_addr[w_push_ptr] <= hdr_start_addr;
            r_q_ext[w_push_ptr]  <= hdr_extent;
            r_q_str[w_push_ptr]  <= hdr_stride;
        end
    end

    // queue pointers, occupancy and one-cycle status pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_ovf  <= hdr_wr_en && w_full && !abort;
            r_done <= w_fin && w_empty && !abort;
            if (abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_wr_ptr <= r_wr_ptr + PW'(w_rep) + PW'(w_push);
                r_rd_ptr <= r_rd_ptr + PW'(w_pop);
                r_count  <= r_count + (PW+1)'(w_rep) + (PW+1)'(w_push) - (PW+1)'(w_pop);
            end
        end
    end

    // working registers: load on pop, advance the loop nest on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ext <= '0;
            r_str <= '0;
            for (int i = 0; i < LOOP_LEVEL; i++) begin
                r_idx[i]  <= '0;
                r_base[i] <= '0;
            end
        end else if (w_pop) begin
            r_ext <= r_q_ext[r_rd_ptr];
            r_str <= r_q_str[r_rd_ptr];
            for (int i = 0; i < LOOP_LEVEL; i++) begin
                r_idx[i]  <= '0;
                r_base[i] <= r_q_addr[r_rd_ptr];
            end
        end else if (w_acc) begin
            for (int i = 0; i < LOOP_LEVEL; i++) begin
                r_idx[i]  <= w_nidx[i];
                r_base[i] <= w_nbase[i];
            end
        end
    end
endmodule

// File: tb/tb_glb_dma_ld_nd.sv
// tb/tb_glb_dma_ld_nd.sv - scoreboard testbench for glb_dma_ld_nd
module tb_glb_dma_ld_nd;
    localparam int QD  = 4;
    localparam int LL  = 3;
    localparam int AW  = 22;
    localparam int CW  = 21;
    localparam int QCW = $clog2(QD) + 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           hdr_wr_en = 1'b0;
    logic [AW-1:0]  hdr_start_addr = '0;
    logic [LL*CW-1:0] hdr_extent = '0;
    logic [LL*AW-1:0] hdr_stride = '0;
    logic           hdr_repeat_on = 1'b0;
    logic           hdr_full, hdr_overflow;
    logic [QCW-1:0] queue_count;
    logic           start_pulse = 1'b0;
    logic           abort = 1'b0;
    logic           rd_en;
    logic [AW-1:0]  rd_addr;
    logic           rd_ready = 1'b0;
    logic           busy, done_pulse;

    glb_dma_ld_nd #(.QUEUE_DEPTH(QD), .LOOP_LEVEL(LL), .GLB_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .hdr_wr_en(hdr_wr_en), .hdr_start_addr(hdr_start_addr),
        .hdr_extent(hdr_extent), .hdr_stride(hdr_stride), .hdr_repeat_on(hdr_repeat_on),
        .hdr_full(hdr_full), .hdr_overflow(hdr_overflow), .queue_count(queue_count),
        .start_pulse(start_pulse), .abort(abort), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_ready(rd_ready), .busy(busy), .done_pulse(done_pulse)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [AW-1:0] exp_q[$];
    int  cyc = 0, acc_cnt = 0, done_cnt = 0, ovf_cnt = 0;
    int  done_cyc = 0, last_acc_cyc = 0, first_acc_cyc = -1;
    int  m_cnt = 0;
    bit  rep_mode = 1'b0;
    bit  rnd_rdy = 1'b0;
    bit  stall_prev = 1'b0;
    logic [AW-1:0] stall_addr = '0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [LL*CW-1:0] mk_ext(input int a, input int b, input int c);
        return {CW'(c), CW'(b), CW'(a)};
    endfunction

    function automatic logic [LL*AW-1:0] mk_str(input int a, input int b, input int c);
        return {AW'(a), AW'(b), AW'(c)} ;
    endfunction

    // reference: address = start + sum(k_i * stride_i) mod 2^AW, level 0 innermost
    function automatic void gen(input logic [AW-1:0] st, input logic [LL*CW-1:0] ex, input logic [LL*AW-1:0] sd);
        int e0, e1, e2;
        logic [AW-1:0] s0, s1, s2, a;
        e0 = int'(ex[0 +: CW]);  e1 = int'(ex[CW +: CW]);  e2 = int'(ex[2*CW +: CW]);
        s0 = sd[0 +: AW];        s1 = sd[AW +: AW];        s2 = sd[2*AW +: AW];
        for (int k2 = 0; k2 < e2; k2++)
            for (int k1 = 0; k1 < e1; k1++)
                for (int k0 = 0; k0 < e0; k0++) begin
                    a = st + AW'(k0) * s0 + AW'(k1) * s1 + AW'(k2) * s2;
                    exp_q.push_back(a);
                end
    endfunction

    // monitor: compares every accepted read against the scoreboard
    always @(negedge clk) begin
        logic [AW-1:0] e;
        cyc++;
        if (!reset_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && rd_en) chk("stall_hold", rd_addr, stall_addr);
            if (rd_en && rd_ready) begin
                acc_cnt++;
                last_acc_cyc = cyc;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", rd_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_addr", rd_addr, e);
                    if (rep_mode) exp_q.push_back(e);
                end
            end
            stall_prev = rd_en && !rd_ready;
            stall_addr = rd_addr;
            if (done_pulse) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (hdr_overflow) ovf_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rnd_rdy) rd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_hdr(input logic [AW-1:0] st, input logic [LL*CW-1:0] ex, input logic [LL*AW-1:0] sd, input bit rep);
        hdr_wr_en = 1'b1;
        hdr_start_addr = st;
        hdr_extent = ex;
        hdr_stride = sd;
        hdr_repeat_on = rep;
        if (m_cnt < QD) begin
            m_cnt++;
            gen(st, ex, sd);
        end
        step(1);
        hdr_wr_en = 1'b0;
        hdr_repeat_on = 1'b0;
    endtask

    task automatic push_rand();
        logic [LL*CW-1:0] ex;
        bit rep;
        for (int i = 0; i < LL; i++)
            ex[i*CW +: CW] = ($urandom_range(0, 9) == 0) ? '0 : CW'($urandom_range(1, 3));
`ifdef GLB_DMA_LD_REPEAT_EN
        rep = 1'b0;
`else
        rep = 1'($urandom_range(0, 1));
`endif
        push_hdr(AW'($urandom), ex, {AW'($urandom), AW'($urandom), AW'($urandom)}, rep);
    endtask

    task automatic start_run();
        start_pulse = 1'b1;
        step(1);
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < bound) begin
            step(1);
            n++;
        end
        step(2);
        chk({name, "_done_once"}, done_cnt - d0, 1);
        chk({name, "_drained"}, exp_q.size(), 0);
        m_cnt = 0;
    endtask

    task automatic check_aborted(input string name);
        int d0 = done_cnt;
        abort = 1'b1;
        rd_ready = 1'b0;
        exp_q.delete();
        rep_mode = 1'b0;
        step(1);
        abort = 1'b0;
        chk({name, "_rd_en"}, rd_en, 0);
        chk({name, "_count"}, queue_count, 0);
        chk({name, "_busy"}, busy, 0);
        step(10);
        chk({name, "_no_done"}, done_cnt - d0, 0);
        m_cnt = 0;
    endtask

    initial begin
        int n, ov0;
        #12;
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_count", queue_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_pulse, 0);
        chk("rst_full", hdr_full, 0);
        chk("rst_ovf", hdr_overflow, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1);

        start_run();
        step(1);
        chk("start_empty_ignored", busy, 0);

        rd_ready = 1'b1;
        push_hdr(22'h100, mk_ext(4, 2, 1), mk_str(0, 'h40, 8), 1'b0);
        chk("one_hdr_count", queue_count, 1);
        acc_cnt = 0;
        start_run();
        wait_done("nest", 200);
        chk("nest_reads", acc_cnt, 8);
        chk("nest_done_latency", done_cyc - last_acc_cyc, 1);

        push_hdr(AW'($urandom), mk_ext(2, 1, 1), mk_str(0, 0, 'h10), 1'b0);
        push_hdr(AW'($urandom), mk_ext(2, 1, 1), mk_str(0, 0, 'h20), 1'b0);
        acc_cnt = 0;
        first_acc_cyc = -1;
        start_run();
        wait_done("two_hdr", 200);
        chk("two_hdr_reads", acc_cnt, 4);
        chk("two_hdr_no_bubble", last_acc_cyc - first_acc_cyc + 1, 4);

        ov0 = ovf_cnt;
        for (int i = 0; i < 3; i++) push_rand();
        chk("three_not_full", hdr_full, 0);
        push_rand();
        chk("four_full", hdr_full, 1);
        push_rand();
        step(2);
        chk("ovf_once", ovf_cnt - ov0, 1);
        chk("ovf_count", queue_count, 4);
        rnd_rdy = 1'b1;
        start_run();
        wait_done("ovf_drain", 2000);
        rnd_rdy = 1'b0;
        rd_ready = 1'b1;

        push_hdr(AW'($urandom), mk_ext(4, 1, 1), mk_str(0, 0, 'h4), 1'b0);
        start_run();
        rd_ready = 1'b1;
        step(1);
        rd_ready = 1'b0;
        step(2);
        rd_ready = 1'b1;
        wait_done("stall", 200);

        push_hdr(22'h200, mk_ext(2, 0, 2), mk_str(1, 2, 3), 1'b0);
        push_hdr(22'h3A0, mk_ext(1, 1, 1), mk_str(1, 2, 3), 1'b0);
        acc_cnt = 0;
        start_run();
        wait_done("zero_ext", 200);
        chk("zero_ext_reads", acc_cnt, 1);

        push_hdr(AW'($urandom), mk_ext(3, 3, 3), mk_str(5, 6, 7), 1'b0);
        push_hdr(AW'($urandom), mk_ext(3, 3, 3), mk_str(5, 6, 7), 1'b0);
        start_run();
        step(5);
        check_aborted("abort");

`ifdef GLB_DMA_LD_REPEAT_EN
        push_hdr(AW'($urandom), mk_ext(3, 1, 1), mk_str(0, 0, 'h30), 1'b1);
        rep_mode = 1'b1;
        acc_cnt = 0;
        rnd_rdy = 1'b1;
        start_run();
        step(40);
        rnd_rdy = 1'b0;
        chk("repeat_busy", busy, 1);
        chk("repeat_count", queue_count, 1);
        chk("repeat_looped", acc_cnt > 9, 1);
        check_aborted("repeat_abort");
`endif

        for (int it = 0; it < 25; it++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) push_rand();
            chk("rand_count", queue_count, m_cnt);
            rnd_rdy = 1'b1;
            start_run();
            wait_done("rand", 2000);
            rnd_rdy = 1'b0;
            rd_ready = 1'b1;
        end

        push_hdr(AW'($urandom), mk_ext(3, 3, 3), mk_str(1, 1, 1), 1'b0);
        start_run();
        step(4);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", rd_en, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", rd_addr, 0);
        chk("mid_rst_count", queue_count, 0);
        exp_q.delete();
        m_cnt = 0;
        n = done_cnt;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(10);
        chk("mid_rst_no_done", done_cnt - n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/glb_dma_ld_nd.md
GLB_DMA_LD_ND -- requirements
Module: glb_dma_ld_nd

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, header queue entries (power of two, >=2).
REQ-002 SHALL have parameter LOOP_LEVEL, default 3, number of nested address loops (>=1).
REQ-003 SHALL have parameter GLB_ADDR_WIDTH, default 22, byte address width.
REQ-004 SHALL have parameter CNT_WIDTH, default 21, per-level extent width.
REQ-005 SHALL have ports:
 clk  in  1  single clock;
 reset_n  in  1  asynchronous, active-low reset;
 hdr_wr_en  in  1  push header;
 hdr_start_addr  in  GLB_ADDR_WIDTH  first address;
 hdr_extent  in  LOOP_LEVEL*CNT_WIDTH  iterations per level, level 0 in LSBs;
 hdr_stride  in  LOOP_LEVEL*GLB_ADDR_WIDTH  address increment per level;
 hdr_repeat_on  in  1  header recirculates;
 hdr_full  out  1  queue full;
 hdr_overflow  out  1  one-cycle pulse, push dropped;
 queue_count  out  $clog2(QUEUE_DEPTH)+1  occupancy;
 start_pulse  in  1  begin streaming;
 abort  in  1  synchronous flush;
 rd_en  out  1  read request valid;
 rd_addr  out  GLB_ADDR_WIDTH  read address;
 rd_ready  in  1  request accepted when rd_en&rd_ready;
 busy  out  1  state==RUN;
 done_pulse  out  1  one-cycle pulse, stream finished.

Function
REQ-006 Queue SHALL be FIFO; hdr_full = (queue_count==QUEUE_DEPTH).
REQ-007 Push with hdr_full=1 SHALL be dropped and pulse hdr_overflow next cycle, even if a pop occurs the same cycle.
REQ-008 FSM states SHALL be IDLE and RUN only.
REQ-009 IDLE->RUN on start_pulse with queue_count>0: pop head into working registers; rd_en first high the following cycle.
REQ-010 start_pulse in RUN, or in IDLE with empty queue, SHALL be ignored.
REQ-011 Working state: per-level counters idx[i] and base addresses base[i], all base[i] loaded with start_addr on pop; rd_addr = base[0].
REQ-012 In RUN rd_en SHALL be 1; on acceptance idx[0] increments and base[0] += stride[0].
REQ-013 When idx[i] reaches extent[i]-1 and increments, idx[i] clears and level i+1 advances: base[i+1] += stride[i+1], and base[j<=i] := new base[i+1].
REQ-014 Address arithmetic SHALL wrap modulo 2^GLB_ADDR_WIDTH; no carry out.
REQ-015 Reads per header SHALL equal product of extents; a header with any extent 0 SHALL be consumed in one cycle with zero reads.
REQ-016 On acceptance of a header's last address: if queue non-empty, next header SHALL pop the same cycle and its first address be presented the next cycle (no bubble); else RUN->IDLE and done_pulse one cycle later.
REQ-017 rd_ready=0 SHALL hold rd_addr and all counters stable.
REQ-018 abort SHALL, next cycle, empty queue, return to IDLE, drop rd_en, suppress done_pulse; a same-cycle push is discarded.

Reset
REQ-019 reset_n low SHALL asynchronously force IDLE, queue empty, counters/base zero, all outputs 0 (rd_addr 0, queue_count 0).
REQ-020 Reset mid-RUN SHALL drop rd_en immediately; no done_pulse after release.

Configuration
REQ-021 With GLB_DMA_LD_REPEAT_EN defined, a popped header with repeat_on=1 SHALL be re-appended at the tail in the pop cycle; this happens before any external push, which is dropped if the combined occupancy would exceed QUEUE_DEPTH.
REQ-022 Without GLB_DMA_LD_REPEAT_EN, hdr_repeat_on SHALL be ignored and not stored.

Verification
REQ-023 One header, start 0x100, extents {4,2,1}, strides {8,0x40,0}, rd_ready=1 -> addrs 0x100,0x108,0x110,0x118,0x140,0x148,0x150,0x158; done_pulse one cycle after last.
REQ-024 Two headers queued, 2x1x1 each -> 4 consecutive rd_en cycles, no bubble, single done_pulse.
REQ-025 Push 5 headers while idle (depth 4) -> hdr_full after 4th, hdr_overflow once, queue_count=4.
REQ-026 rd_ready toggled 1,0,0,1 -> rd_addr held during stalls, sequence unchanged.
REQ-027 REPEAT_EN, one repeat header extent 3 -> address pattern loops indefinitely; abort mid-stream -> rd_en 0 next cycle, queue_count 0, no done_pulse.
REQ-028 Header with extent[1]=0 followed by a 1x1x1 header -> only second header's address issued.
